// File: rtl/branch_unit_pkg.sv
// Shared widths, opcode classification masks, condition codes and BHT counter
// encodings for the branch unit and its condition evaluator.
package branch_unit_pkg;

   localparam int FLAGSIZE    = 4;
   localparam int OPCODESIZE  = 11;
   localparam int REGADDRSIZE = 5;

   // Mask/bitset pairs: (opcode & MASK) == BITS identifies the class.
   // The CB mask leaves opcode[3] open so it covers both CBZ and CBNZ.
   localparam logic [OPCODESIZE-1:0] B_MASK     = 11'b111111_00000;
   localparam logic [OPCODESIZE-1:0] B_BITS     = 11'b000101_00000;
   localparam logic [OPCODESIZE-1:0] CB_MASK    = 11'b1111111_0000;
   localparam logic [OPCODESIZE-1:0] CB_BITS    = 11'b1011010_0000;
   localparam logic [OPCODESIZE-1:0] BFLAG_MASK = 11'b11111111_000;
   localparam logic [OPCODESIZE-1:0] BFLAG_BITS = 11'b01010100_000;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } nzvc_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0,
      COND_NE = 4'h1,
      COND_HS = 4'h2,
      COND_LO = 4'h3,
      COND_MI = 4'h4,
      COND_PL = 4'h5,
      COND_VS = 4'h6,
      COND_VC = 4'h7,
      COND_HI = 4'h8,
      COND_LS = 4'h9,
      COND_GE = 4'ha,
      COND_LT = 4'hb,
      COND_GT = 4'hc,
      COND_LE = 4'hd
   } cond_e;

   typedef enum logic [1:0] {
      BHT_SNT = 2'b00,
      BHT_WNT = 2'b01,
      BHT_WT  = 2'b10,
      BHT_ST  = 2'b11
   } bht_cnt_e;

   // Two-bit saturating counter step; the extremes hold.
   function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != BHT_ST) begin
            nxt = cnt + 2'd1;
         end else begin
            nxt = cnt;
         end
      end else begin
         if (cnt != BHT_SNT) begin
            nxt = cnt - 2'd1;
         end else begin
            nxt = cnt;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch classification and outcome: B, CBZ/CBNZ and B.cond
// evaluated against a supplied NZVC value and ALU zero result.
module branch_cond_eval
   import branch_unit_pkg::*;
(
   input  logic [OPCODESIZE-1:0] i_opcode,
   input  logic [3:0]            i_cond,
   input  logic [FLAGSIZE-1:0]   i_flags,
   input  logic                  i_zero,
   output logic                  o_is_branch,
   output logic                  o_taken
);

   nzvc_t w_f;
   logic  w_is_b;
   logic  w_is_cb;
   logic  w_is_bflag;
   logic  w_cond_true;

   assign w_f        = i_flags;
   assign w_is_b     = ((i_opcode & B_MASK) == B_BITS);
   assign w_is_cb    = ((i_opcode & CB_MASK) == CB_BITS);
   assign w_is_bflag = ((i_opcode & BFLAG_MASK) == BFLAG_BITS);

   // Condition-code table; codes 0xe and 0xf never take.
   always_comb begin
      w_cond_true = 1'b0;
      case (i_cond)
         COND_EQ: w_cond_true = w_f.z;
         COND_NE: w_cond_true = ~w_f.z;
         COND_HS: w_cond_true = w_f.c;
         COND_LO: w_cond_true = ~w_f.c;
         COND_MI: w_cond_true = w_f.n;
         COND_PL: w_cond_true = ~w_f.n;
         COND_VS: w_cond_true = w_f.v;
         COND_VC: w_cond_true = ~w_f.v;
         COND_HI: w_cond_true = w_f.c & ~w_f.z;
         COND_LS: w_cond_true = ~w_f.c | w_f.z;
         COND_GE: w_cond_true = (w_f.n == w_f.v);
         COND_LT: w_cond_true = (w_f.n != w_f.v);
         COND_GT: w_cond_true = ~w_f.z & (w_f.n == w_f.v);
         COND_LE: w_cond_true = w_f.z | (w_f.n != w_f.v);
         default: w_cond_true = 1'b0;
      endcase
   end

   // opcode[3] separates CBNZ (1) from CBZ (0).
   always_comb begin
      o_is_branch = w_is_b | w_is_cb | w_is_bflag;
      o_taken     = 1'b0;
      if (w_is_b) begin
         o_taken = 1'b1;
      end else if (w_is_cb) begin
         o_taken = i_opcode[3] ? ~i_zero : i_zero;
      end else if (w_is_bflag) begin
         o_taken = w_cond_true;
      end else begin
         o_taken = 1'b0;
      end
   end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: NZVC flag register with same-cycle bypass, BHT of 2-bit counters
// for fetch prediction, execute-stage resolve. Optional counters: BRANCH_STATS_EN.
module branch_unit
   import branch_unit_pkg::*;
#(
   parameter int PCW   = 64,
   parameter int DEPTH = 64
`ifdef BRANCH_STATS_EN
   ,
   parameter int CNTW  = 32
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PCW-1:0]         pred_pc,
   output logic                   pred_taken,
   input  logic                   flag_we,
   input  logic [FLAGSIZE-1:0]    flag_in,
   output logic [FLAGSIZE-1:0]    flags,
   input  logic                   res_valid,
   input  logic [PCW-1:0]         res_pc,
   input  logic [OPCODESIZE-1:0]  res_opcode,
   input  logic [REGADDRSIZE-1:0] res_rd,
   input  logic                   res_zero,
   input  logic                   res_pred_taken,
   output logic                   res_taken,
   output logic                   mispredict,
   output logic                   res_is_branch
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNTW-1:0]        stat_branches,
   output logic [CNTW-1:0]        stat_mispredicts
`endif
);

   localparam int IDXW = $clog2(DEPTH);

   logic [1:0]          r_bht [DEPTH];
   logic [FLAGSIZE-1:0] r_flags;
   logic                r_res_taken;
   logic                r_mispredict;
   logic                r_res_is_branch;

   logic [IDXW-1:0]     w_pred_idx;
   logic [IDXW-1:0]     w_res_idx;
   logic [1:0]          w_pred_cnt;
   logic [FLAGSIZE-1:0] w_eff_flags;
   logic                w_is_branch;
   logic                w_taken;
   logic                w_update;
   logic                w_unused_bits;

   assign w_pred_idx = pred_pc[IDXW+1:2];
   assign w_res_idx  = res_pc[IDXW+1:2];
   assign w_pred_cnt = r_bht[w_pred_idx];
   assign pred_taken = w_pred_cnt[1];

   // A flag write in the same cycle belongs to the older instruction, so it wins.
   assign w_eff_flags = flag_we ? flag_in : r_flags;
   assign w_update    = res_valid & w_is_branch;

   // PC bits outside the index and the top Rt bit carry no information here.
   assign w_unused_bits = ^{pred_pc[PCW-1:IDXW+2], pred_pc[1:0],
                            res_pc[PCW-1:IDXW+2], res_pc[1:0],
                            res_rd[REGADDRSIZE-1:4]};

   branch_cond_eval u_cond_eval (
      .i_opcode    (res_opcode),
      .i_cond      (res_rd[3:0]),
      .i_flags     (w_eff_flags),
      .i_zero      (res_zero),
      .o_is_branch (w_is_branch),
      .o_taken     (w_taken)
   );

   // Flag register and single-cycle resolve pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags         <= 4'b0000;
         r_res_taken     <= 1'b0;
         r_mispredict    <= 1'b0;
         r_res_is_branch <= 1'b0;
      end else begin
         if (flag_we) begin
            r_flags <= flag_in;
         end
         r_res_taken     <= res_valid & w_taken;
         r_mispredict    <= res_valid & (w_taken ^ res_pred_taken);
         r_res_is_branch <= w_update;
      end
   end

   // BHT: whole table back to weakly-not-taken in one cycle; reads see pre-update value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_bht[i] <= BHT_WNT;
         end
      end else if (w_update) begin
         r_bht[w_res_idx] <= bht_next(r_bht[w_res_idx], w_taken);
      end
   end

   assign flags         = r_flags;
   assign res_taken     = r_res_taken;
   assign mispredict    = r_mispredict;
   assign res_is_branch = r_res_is_branch;

`ifdef BRANCH_STATS_EN
   logic [CNTW-1:0] r_stat_branches;
   logic [CNTW-1:0] r_stat_mispredicts;

   // Wrapping event counters; non-branch flushes count as mispredicts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else begin
         if (w_update) begin
            r_stat_branches <= r_stat_branches + 1'b1;
         end
         if (res_valid && (w_taken ^ res_pred_taken)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
         end
      end
   end

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed plus random scoreboard bench for branch_unit.
module tb_branch_unit;

   localparam logic [10:0] OP_B     = 11'b000101_00000;
   localparam logic [10:0] OP_CBZ   = 11'b10110100_000;
   localparam logic [10:0] OP_CBNZ  = 11'b10110101_000;
   localparam logic [10:0] OP_BCOND = 11'b01010100_000;
   localparam logic [10:0] OP_ADD   = 11'b10001011_000;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pred_pc;
   logic        pred_taken;
   logic        flag_we;
   logic [3:0]  flag_in;
   logic [3:0]  flags;
   logic        res_valid;
   logic [63:0] res_pc;
   logic [10:0] res_opcode;
   logic [4:0]  res_rd;
   logic        res_zero;
   logic        res_pred_taken;
   logic        res_taken;
   logic        mispredict;
   logic        res_is_branch;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
   logic [31:0] exp_sb;
   logic [31:0] exp_sm;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [2:0]  sb_q [$];
   logic [1:0]  m_bht [64];
   logic [3:0]  m_flags;

   always #5 clk = ~clk;

   branch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .pred_pc        (pred_pc),
      .pred_taken     (pred_taken),
      .flag_we        (flag_we),
      .flag_in        (flag_in),
      .flags          (flags),
      .res_valid      (res_valid),
      .res_pc         (res_pc),
      .res_opcode     (res_opcode),
      .res_rd         (res_rd),
      .res_zero       (res_zero),
      .res_pred_taken (res_pred_taken),
      .res_taken      (res_taken),
      .mispredict     (mispredict),
      .res_is_branch  (res_is_branch)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, v, cc, base;
      n = f[3]; z = f[2]; v = f[1]; cc = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b0;
      endcase
      if (c >= 4'd14) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   // Returns {is_branch, taken}.
   function automatic logic [1:0] ref_outcome(input logic [10:0] opc, input logic [4:0] rd,
                                              input logic zero, input logic [3:0] f);
      if (opc[10:5] == 6'b000101) return 2'b11;
      if (opc[10:4] == 7'b1011010) return {1'b1, opc[3] ? !zero : zero};
      if (opc[10:3] == 8'b01010100) return {1'b1, cond_ref(rd[3:0], f)};
      return 2'b00;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_flags = 4'b0000;
`ifdef BRANCH_STATS_EN
      exp_sb = 32'd0;
      exp_sm = 32'd0;
`endif
   endtask

   task automatic resolve(input logic [63:0] pc, input logic [10:0] opc, input logic [4:0] rd,
                          input logic zero, input logic pt, input logic fwe, input logic [3:0] fin,
                          input logic exp_br, input logic exp_tk, input string tag);
      logic [2:0] e;
      logic [5:0] idx;
      res_valid = 1'b1; res_pc = pc; res_opcode = opc; res_rd = rd;
      res_zero = zero; res_pred_taken = pt; flag_we = fwe; flag_in = fin;
      sb_q.push_back({exp_br, exp_tk, exp_tk ^ pt});
      #1;
      check({tag, " pred_pre"}, pred_taken, m_bht[pred_pc[7:2]][1]);
      tick();
      res_valid = 1'b0;
      flag_we   = 1'b0;
      if (fwe) m_flags = fin;
      if (exp_br) begin
         idx = pc[7:2];
         if (exp_tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
         else if (!exp_tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
      end
`ifdef BRANCH_STATS_EN
      if (exp_br) exp_sb = exp_sb + 32'd1;
      if (exp_tk ^ pt) exp_sm = exp_sm + 32'd1;
`endif
      e = sb_q.pop_front();
      check({tag, " is_branch"}, res_is_branch, e[2]);
      check({tag, " taken"}, res_taken, e[1]);
      check({tag, " mispredict"}, mispredict, e[0]);
      check({tag, " flags"}, flags, m_flags);
   endtask

   task automatic pred_check(input logic [63:0] pc, input logic exp, input string tag);
      pred_pc = pc;
      #1;
      check(tag, pred_taken, exp);
   endtask

   initial begin
      reset = 1'b1; pred_pc = 64'h0; flag_we = 1'b0; flag_in = 4'h0;
      res_valid = 1'b0; res_pc = 64'h0; res_opcode = 11'h0; res_rd = 5'h0;
      res_zero = 1'b0; res_pred_taken = 1'b0;
      model_reset();
      tick();
      tick();
      reset = 1'b0;
      check("rst flags", flags, 4'b0000);
      check("rst taken", res_taken, 1'b0);
      check("rst mispredict", mispredict, 1'b0);
      check("rst is_branch", res_is_branch, 1'b0);
      pred_check(64'h0, 1'b0, "rst pred 0x0");
      pred_check(64'h40, 1'b0, "rst pred 0x40");
      pred_check(64'hFC, 1'b0, "rst pred 0xFC");

      // B.EQ resolved with flags bypassed from the same-cycle write
      resolve(64'h10, OP_BCOND, 5'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, "beq_bypass");
      check("beq flags", flags, 4'b0100);
      pred_check(64'h10, 1'b1, "beq pred");
      tick();
      check("pulse taken", res_taken, 1'b0);
      check("pulse mispredict", mispredict, 1'b0);
      check("pulse is_branch", res_is_branch, 1'b0);

      // CBZ x3 saturates at 11, CBNZ x2 walks back to 01
      pred_pc = 64'h20;
      resolve(64'h20, OP_CBZ, 5'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "cbz1");
      resolve(64'h20, OP_CBZ, 5'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "cbz2");
      resolve(64'h20, OP_CBZ, 5'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "cbz3");
      pred_check(64'h20, 1'b1, "cbz pred");
      resolve(64'h20, OP_CBNZ, 5'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "cbnz1");
      pred_check(64'h20, 1'b1, "cbnz1 pred");
      resolve(64'h20, OP_CBNZ, 5'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "cbnz2");
      pred_check(64'h20, 1'b0, "cbnz2 pred");

      // Reserved condition codes: branch, never taken, counter decrements
      pred_pc = 64'h10;
      resolve(64'h10, OP_BCOND, 5'he, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, "cond_e");
      pred_check(64'h10, 1'b0, "cond_e pred");
      resolve(64'h10, OP_BCOND, 5'hf, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, "cond_f");
      check("cond_f flags", flags, 4'b1111);
      resolve(64'h10, OP_B, 5'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "b_after_f");
      pred_check(64'h10, 1'b0, "cond_f floor pred");

      // Non-branch flush leaves the BHT alone
      resolve(64'h10, OP_ADD, 5'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "nonbranch");
      pred_check(64'h10, 1'b0, "nonbranch pred");
      resolve(64'h10, OP_B, 5'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "b_after_nb");
      pred_check(64'h10, 1'b1, "b_after_nb pred");

      // Same-index predict and update: pre-edge read returns the old counter
      pred_pc = 64'h20;
      resolve(64'h20, OP_CBZ, 5'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "collide");
      pred_check(64'h20, 1'b1, "collide post");
      resolve(64'h20, OP_CBZ, 5'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "to_st");

      // Reset wins over a concurrent resolve and flag write
      reset = 1'b1; res_valid = 1'b1; res_pc = 64'h20; res_opcode = OP_B;
      res_pred_taken = 1'b1; flag_we = 1'b1; flag_in = 4'b1111;
      tick();
      reset = 1'b0; res_valid = 1'b0; flag_we = 1'b0;
      model_reset();
      check("mid_rst flags", flags, 4'b0000);
      check("mid_rst taken", res_taken, 1'b0);
      check("mid_rst mispredict", mispredict, 1'b0);
      check("mid_rst is_branch", res_is_branch, 1'b0);
      pred_check(64'h20, 1'b0, "mid_rst pred");
`ifdef BRANCH_STATS_EN
      check("mid_rst stat_branches", stat_branches, 32'd0);
      check("mid_rst stat_mispredicts", stat_mispredicts, 32'd0);
`endif
      resolve(64'h20, OP_B, 5'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, "post_rst_b");
      pred_check(64'h20, 1'b1, "post_rst 01->10");

      // PCs differing above the index alias to one entry
      resolve(64'hABCD_0000_0000_0120, OP_B, 5'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "alias");
      pred_check(64'h0000_0000_0000_0020, 1'b1, "alias pred");
      resolve(64'h0000_0000_0000_0220, OP_CBZ, 5'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "alias_dec1");
      resolve(64'h0000_0000_0000_0020, OP_CBZ, 5'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, "alias_dec2");
      pred_check(64'hFFFF_0000_0000_0020, 1'b0, "alias pred dec");

      // Random mix against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [10:0] opc;
         logic [4:0]  rd;
         logic [63:0] pc;
         logic        z, pt, fwe;
         logic [3:0]  fin, eff;
         logic [1:0]  o;
         rd = 5'($urandom);
         case ($urandom_range(0, 4))
            0: opc = OP_B | {6'b0, 5'($urandom)};
            1: opc = OP_CBZ | {8'b0, 3'($urandom)};
            2: opc = OP_CBNZ | {8'b0, 3'($urandom)};
            3: begin
               opc = OP_BCOND | {8'b0, 3'($urandom)};
               rd  = {1'b0, 4'($urandom)};
            end
            default: opc = OP_ADD;
         endcase
         pc  = {$urandom(), $urandom()};
         z   = 1'($urandom);
         pt  = 1'($urandom);
         fwe = 1'($urandom);
         fin = 4'($urandom);
         pred_pc = ($urandom_range(0, 3) == 0) ? pc : {$urandom(), $urandom()};
         eff = fwe ? fin : m_flags;
         o   = ref_outcome(opc, rd, z, eff);
         resolve(pc, opc, rd, z, pt, fwe, fin, o[1], o[0], "rand");
      end
`ifdef BRANCH_STATS_EN
      check("end stat_branches", stat_branches, exp_sb);
      check("end stat_mispredicts", stat_mispredicts, exp_sm);
`endif
      check("scoreboard drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
